// File: rtl/clint_multi_if.sv
// AXI4-Lite channel bundle (32-bit address/data) shared by the CLINT and its bus master.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: free-running 64-bit mtime, per-hart mtimecmp/msip,
// AXI4-Lite register access with independent read and write channels.
module clint_multi #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_lite_if.slave            s,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip_o
);

  typedef enum logic [2:0] {K_NONE, K_MSIP, K_CMP_LO, K_CMP_HI, K_TIME_LO, K_TIME_HI} kind_t;
  typedef struct packed { kind_t kind; logic [3:0] hart; } dec_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Unaligned, out-of-window and absent-hart addresses all decode to K_NONE.
  function automatic dec_t decode(input logic [31:0] addr);
    dec_t        d;
    logic [31:0] off;
    d.kind = K_NONE;
    d.hart = 4'd0;
    off    = addr - BASE_ADDR;
    if (addr[1:0] == 2'b00) begin
      if (off < 32'(4 * NUM_HARTS)) begin
        d.kind = K_MSIP;
        d.hart = off[5:2];
      end else if (off >= 32'h0000_4000 && off < 32'h0000_4000 + 32'(8 * NUM_HARTS)) begin
        d.kind = off[2] ? K_CMP_HI : K_CMP_LO;
        d.hart = off[6:3];
      end else if (off == 32'h0000_BFF8) begin
        d.kind = K_TIME_LO;
      end else if (off == 32'h0000_BFFC) begin
        d.kind = K_TIME_HI;
      end else begin
        d.kind = K_NONE;
      end
    end else begin
      d.kind = K_NONE;
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  r_state_t             r_state, r_next;
  w_state_t             w_state, w_next;
  logic [31:0]          aw_addr, w_data;
  logic [3:0]           w_strb;
  logic                 commit, wr_en;
  logic [31:0]          c_addr, c_data;
  logic [3:0]           c_strb;
  dec_t                 wdec, rdec;
  logic [31:0]          rd_val;
  logic [63:0]          mtime;
  logic [15:0]          presc;
  logic                 tick;
  logic [NUM_HARTS-1:0] msip;
  logic [63:0]          mtimecmp [NUM_HARTS];

  assign s.arready = (r_state == R_IDLE);
  assign s.rvalid  = (r_state == R_RESP);
  assign s.awready = (w_state == W_IDLE) || (w_state == W_DATA);
  assign s.wready  = (w_state == W_IDLE) || (w_state == W_ADDR);
  assign s.bvalid  = (w_state == W_RESP);
  assign msip_o    = msip;
  assign tick      = (presc == 16'(TICK_DIV - 1));

  // Read address decode and data mux.
  always_comb begin
    rdec   = decode(s.araddr);
    rd_val = 32'd0;
    case (rdec.kind)
      K_MSIP:    for (int h = 0; h < NUM_HARTS; h++)
                   rd_val = (rdec.hart == 4'(h)) ? {31'd0, msip[h]} : rd_val;
      K_CMP_LO:  for (int h = 0; h < NUM_HARTS; h++)
                   rd_val = (rdec.hart == 4'(h)) ? mtimecmp[h][31:0] : rd_val;
      K_CMP_HI:  for (int h = 0; h < NUM_HARTS; h++)
                   rd_val = (rdec.hart == 4'(h)) ? mtimecmp[h][63:32] : rd_val;
      K_TIME_LO: rd_val = mtime[31:0];
      K_TIME_HI: rd_val = mtime[63:32];
      default:   rd_val = 32'd0;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s.arvalid) r_next = R_RESP; else r_next = R_IDLE;
      R_RESP:  if (s.rready)  r_next = R_IDLE; else r_next = R_RESP;
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM next state; the commit uses whichever half arrives live this cycle.
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_addr = aw_addr;
    c_data = w_data;
    c_strb = w_strb;
    case (w_state)
      W_IDLE: begin
        if (s.awvalid && s.wvalid) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_addr = s.awaddr;
          c_data = s.wdata;
          c_strb = s.wstrb;
        end else if (s.awvalid) begin
          w_next = W_ADDR;
        end else if (s.wvalid) begin
          w_next = W_DATA;
        end else begin
          w_next = W_IDLE;
        end
      end
      W_ADDR: begin
        if (s.wvalid) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_data = s.wdata;
          c_strb = s.wstrb;
        end else begin
          w_next = W_ADDR;
        end
      end
      W_DATA: begin
        if (s.awvalid) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_addr = s.awaddr;
        end else begin
          w_next = W_DATA;
        end
      end
      W_RESP:  if (s.bready) w_next = W_IDLE; else w_next = W_RESP;
      default: w_next = W_IDLE;
    endcase
    wdec  = decode(c_addr);
    wr_en = commit && (wdec.kind != K_NONE) && (c_strb != 4'd0);
  end

  // Bus-side state: FSMs, captured AW/W halves and registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      s.rdata <= 32'd0;
      s.rresp <= OKAY;
      s.bresp <= OKAY;
      aw_addr <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_state == R_IDLE && s.arvalid) begin
        s.rdata <= rd_val;
        s.rresp <= (rdec.kind == K_NONE) ? SLVERR : OKAY;
      end
      if (w_state == W_IDLE && s.awvalid) aw_addr <= s.awaddr;
      if (w_state == W_IDLE && s.wvalid) begin
        w_data <= s.wdata;
        w_strb <= s.wstrb;
      end
      if (commit) s.bresp <= (wdec.kind == K_NONE) ? SLVERR : OKAY;
    end
  end

  // Timer, compare registers and interrupt outputs; a bus write to mtime wins over the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= 16'd0;
      mtime <= 64'd0;
      msip  <= '0;
      mtip  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (wr_en && wdec.kind == K_TIME_LO)      mtime[31:0]  <= merge(mtime[31:0], c_data, c_strb);
      else if (wr_en && wdec.kind == K_TIME_HI) mtime[63:32] <= merge(mtime[63:32], c_data, c_strb);
      else if (tick)                            mtime        <= mtime + 64'd1;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (wr_en && wdec.hart == 4'(h)) begin
          if (wdec.kind == K_MSIP && c_strb[0]) msip[h] <= c_data[0];
          if (wdec.kind == K_CMP_LO) mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], c_data, c_strb);
          if (wdec.kind == K_CMP_HI) mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], c_data, c_strb);
        end
      end
    end
  end

endmodule
